// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: word type, reset PC, NOP and FSM encoding.
// Kept separate so the ID stage and the testbench can reuse the same constants.
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_3000;
    localparam word_t MIPS_NOP         = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;

    // Branch/jump targets are word addresses; the low two bits carry no meaning here.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Signal bundle between the fetch stage, instruction memory and the ID stage.
// master = fetch stage side, slave = memory / decode side.
interface if_fetch_stage_if;
    import cpu_pkg::*;

    logic  stall;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  imem_req;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;
    logic  if_id_valid;
    word_t if_id_instr;
    word_t if_id_pc;
    word_t if_id_pc4;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load writes all fields, bubble clears only valid,
// otherwise every field holds (stall).
module if_id_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  logic  i_bubble,
    input  word_t i_instr,
    input  word_t i_pc,
    input  word_t i_pc4,
    output logic  o_valid,
    output word_t o_instr,
    output word_t o_pc,
    output word_t o_pc4
);

    logic  r_valid;
    word_t r_instr;
    word_t r_pc;
    word_t r_pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= MIPS_NOP;
            r_pc    <= '0;
            r_pc4   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, valid/ready fetch FSM, delay-slot aware
// redirect handling and a one-entry hold buffer for responses that arrive during a stall.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    if_fetch_stage_if.master fetch
);

    fetch_state_t r_state;
    logic         r_req_en;
    logic         r_redir_pending;
    word_t        r_redir_target;
    word_t        r_pc;
    word_t        r_hold_instr;
    word_t        r_hold_pc;
    word_t        r_hold_pc4;

    logic  w_in_hold;
    logic  w_req;
    logic  w_resp;
    word_t w_pc4;
    word_t w_redir_pc;
    word_t w_next_pc;
    logic  w_ifid_load;
    logic  w_ifid_bubble;
    word_t w_ifid_instr;
    word_t w_ifid_pc;
    word_t w_ifid_pc4;

    // r_req_en keeps imem_req low until the first clock edge after reset release.
    assign w_in_hold  = (r_state == ST_HOLD);
    assign w_req      = r_req_en && !w_in_hold;
    assign w_resp     = w_req && fetch.imem_ready;
    assign w_pc4      = r_pc + 32'd4;
    assign w_redir_pc = align_word(fetch.redirect_pc);

    assign fetch.imem_req  = w_req;
    assign fetch.imem_addr = w_req ? r_pc : '0;

    always_comb begin
        if (fetch.redirect_valid) begin
            w_next_pc = w_redir_pc;
        end else if (r_redir_pending) begin
            w_next_pc = r_redir_target;
        end else begin
            w_next_pc = w_pc4;
        end
    end

    always_comb begin
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        w_ifid_instr  = fetch.imem_rdata;
        w_ifid_pc     = r_pc;
        w_ifid_pc4    = w_pc4;
        if (w_in_hold) begin
            if (!fetch.stall) begin
                w_ifid_load  = 1'b1;
                w_ifid_instr = r_hold_instr;
                w_ifid_pc    = r_hold_pc;
                w_ifid_pc4   = r_hold_pc4;
            end
        end else if (w_resp) begin
            w_ifid_load = !fetch.stall;
        end else begin
            w_ifid_bubble = !fetch.stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_FETCH;
            r_req_en        <= 1'b0;
            r_redir_pending <= 1'b0;
            r_redir_target  <= '0;
            r_pc            <= RESET_PC;
            r_hold_instr    <= MIPS_NOP;
            r_hold_pc       <= '0;
            r_hold_pc4      <= '0;
        end else begin
            r_req_en <= 1'b1;
            case (r_state)
                ST_HOLD: begin
                    // pc already points past the buffered delay slot, so a redirect lands directly.
                    if (fetch.redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (!fetch.stall) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    if (w_resp) begin
                        r_pc            <= w_next_pc;
                        r_redir_pending <= 1'b0;
                        if (fetch.stall) begin
                            r_hold_instr <= fetch.imem_rdata;
                            r_hold_pc    <= r_pc;
                            r_hold_pc4   <= w_pc4;
                            r_state      <= ST_HOLD;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        // The fetch of the current pc is the delay slot; apply the target after it.
                        if (fetch.redirect_valid) begin
                            r_redir_pending <= 1'b1;
                            r_redir_target  <= w_redir_pc;
                        end
                        r_state <= w_req ? ST_WAIT : ST_FETCH;
                    end
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_ifid_load),
        .i_bubble (w_ifid_bubble),
        .i_instr  (w_ifid_instr),
        .i_pc     (w_ifid_pc),
        .i_pc4    (w_ifid_pc4),
        .o_valid  (fetch.if_id_valid),
        .o_instr  (fetch.if_id_instr),
        .o_pc     (fetch.if_id_pc),
        .o_pc4    (fetch.if_id_pc4)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table, async-reset sequence,
// then randomized traffic against a transaction-level reference model.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fetch (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Instruction memory contents are a fixed function of the address.
    function automatic word_t mem_word(input word_t a);
        return {a[15:2], 2'b01, ~a[17:2]};
    endfunction

    always_comb bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

    task automatic check_word(input string name, input word_t act, input word_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input word_t e_addr,
                                 input logic e_valid, input word_t e_instr, input word_t e_pc,
                                 input word_t e_pc4);
        check_bit ({tag, ".imem_req"},    bus.imem_req,    e_req);
        check_word({tag, ".imem_addr"},   bus.imem_addr,   e_addr);
        check_bit ({tag, ".if_id_valid"}, bus.if_id_valid, e_valid);
        check_word({tag, ".if_id_instr"}, bus.if_id_instr, e_instr);
        check_word({tag, ".if_id_pc"},    bus.if_id_pc,    e_pc);
        check_word({tag, ".if_id_pc4"},   bus.if_id_pc4,   e_pc4);
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic rv, input word_t rpc);
        bus.imem_ready     = rdy;
        bus.stall          = stl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Inputs applied for one clock edge, and outputs expected right after that edge.
    typedef struct {
        logic  rdy;
        logic  stl;
        logic  rv;
        word_t rpc;
        logic  e_req;
        word_t e_addr;
        logic  e_valid;
        word_t e_pc;
        word_t e_instr;
        word_t e_pc4;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rdy, input logic stl, input logic rv, input word_t rpc,
                                input logic e_req, input word_t e_addr, input logic e_valid,
                                input word_t e_pc);
        vec_t v;
        v.rdy = rdy; v.stl = stl; v.rv = rv; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_instr = mem_word(e_pc);
        v.e_pc4   = e_pc + 32'd4;
        return v;
    endfunction

    // Reference model state: transaction level, hold buffer as a queue of fetched PCs.
    word_t m_pc;
    bit    m_started;
    bit    m_pend;
    word_t m_tgt;
    word_t m_hold_q [$];
    logic  m_v;
    word_t m_instr, m_ipc, m_ipc4;

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_started = 0; m_pend = 0; m_tgt = '0;
        m_hold_q.delete();
        m_v = 1'b0; m_instr = '0; m_ipc = '0; m_ipc4 = '0;
    endtask

    task automatic model_deliver(input word_t pc);
        m_v = 1'b1; m_instr = mem_word(pc); m_ipc = pc; m_ipc4 = pc + 32'd4;
    endtask

    task automatic model_step(input logic rdy, input logic stl, input logic rv, input word_t rpc);
        word_t tgt;
        word_t fpc;
        bit    req;
        tgt = {rpc[31:2], 2'b00};
        req = m_started && (m_hold_q.size() == 0);
        if (m_hold_q.size() != 0) begin
            if (rv) m_pc = tgt;
            if (!stl) model_deliver(m_hold_q.pop_front());
        end else if (req && rdy) begin
            fpc = m_pc;
            $display("rand fetch pc=%h stall=%b redirect=%b", fpc, stl, rv);
            if (rv) m_pc = tgt;
            else if (m_pend) m_pc = m_tgt;
            else m_pc = m_pc + 32'd4;
            m_pend = 0;
            if (stl) m_hold_q.push_back(fpc);
            else model_deliver(fpc);
        end else begin
            if (rv) begin m_pend = 1; m_tgt = tgt; end
            if (!stl) m_v = 1'b0;
        end
        m_started = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);

        tbl[0]  = mk(1, 0, 0, 32'h0,         1, 32'h3000, 0, 32'h0);
        tbl[1]  = mk(1, 0, 0, 32'h0,         1, 32'h3004, 1, 32'h3000);
        tbl[2]  = mk(0, 0, 0, 32'h0,         1, 32'h3004, 0, 32'h3000);
        tbl[3]  = mk(0, 0, 0, 32'h0,         1, 32'h3004, 0, 32'h3000);
        tbl[4]  = mk(1, 0, 0, 32'h0,         1, 32'h3008, 1, 32'h3004);
        tbl[5]  = mk(1, 0, 1, 32'h3100,      1, 32'h3100, 1, 32'h3008);
        tbl[6]  = mk(1, 0, 0, 32'h0,         1, 32'h3104, 1, 32'h3100);
        tbl[7]  = mk(0, 0, 0, 32'h0,         1, 32'h3104, 0, 32'h3100);
        tbl[8]  = mk(0, 0, 1, 32'h3202,      1, 32'h3104, 0, 32'h3100);
        tbl[9]  = mk(1, 0, 0, 32'h0,         1, 32'h3200, 1, 32'h3104);
        tbl[10] = mk(1, 0, 0, 32'h0,         1, 32'h3204, 1, 32'h3200);
        tbl[11] = mk(1, 0, 0, 32'h0,         1, 32'h3208, 1, 32'h3204);
        tbl[12] = mk(1, 1, 0, 32'h0,         0, 32'h0,    1, 32'h3204);
        tbl[13] = mk(0, 1, 0, 32'h0,         0, 32'h0,    1, 32'h3204);
        tbl[14] = mk(1, 1, 0, 32'h0,         0, 32'h0,    1, 32'h3204);
        tbl[15] = mk(1, 0, 0, 32'h0,         1, 32'h320C, 1, 32'h3208);
        tbl[16] = mk(1, 0, 0, 32'h0,         1, 32'h3210, 1, 32'h320C);
        tbl[17] = mk(1, 1, 0, 32'h0,         0, 32'h0,    1, 32'h320C);
        tbl[18] = mk(1, 1, 1, 32'h3400,      0, 32'h0,    1, 32'h320C);
        tbl[19] = mk(1, 0, 0, 32'h0,         1, 32'h3400, 1, 32'h3210);
        tbl[20] = mk(1, 0, 0, 32'h0,         1, 32'h3404, 1, 32'h3400);
        tbl[21] = mk(1, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h3404);
        tbl[22] = mk(1, 0, 0, 32'h0,         1, 32'h0,    1, 32'hFFFF_FFFC);
        tbl[23] = mk(1, 0, 0, 32'h0,         1, 32'h4,    1, 32'h0);
        tbl[24] = mk(0, 1, 0, 32'h0,         1, 32'h4,    1, 32'h0);
        tbl[25] = mk(0, 0, 0, 32'h0,         1, 32'h4,    0, 32'h0);
        tbl[26] = mk(1, 0, 0, 32'h0,         1, 32'h8,    1, 32'h4);
        // Nothing has been loaded into IF/ID yet after the first edge.
        tbl[0].e_instr = '0;
        tbl[0].e_pc4   = '0;

        repeat (2) @(negedge clk);
        check_outputs("reset", 1'b0, '0, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        #1;
        check_bit("post_release.imem_req", bus.imem_req, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rdy, tbl[i].stl, tbl[i].rv, tbl[i].rpc);
            tick();
            check_outputs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                          tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_pc4);
            $display("vec %0d: imem_req=%b imem_addr=%h if_id_valid=%b if_id_pc=%h",
                     i, bus.imem_req, bus.imem_addr, bus.if_id_valid, bus.if_id_pc);
        end

        // Asynchronous reset in the middle of an unanswered fetch.
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        check_word("midwait.imem_addr", bus.imem_addr, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, '0, 1'b0, '0, '0, '0);
        $display("async reset asserted mid-wait");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0);
        #1;
        check_bit("rerelease.imem_req", bus.imem_req, 1'b0);
        tick();
        check_bit ("restart.imem_req",  bus.imem_req,  1'b1);
        check_word("restart.imem_addr", bus.imem_addr, 32'h3000);
        tick();
        check_bit ("restart.if_id_valid", bus.if_id_valid, 1'b1);
        check_word("restart.if_id_pc",    bus.if_id_pc,    32'h3000);
        $display("restart fetch delivered pc=%h", bus.if_id_pc);

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            logic  rdy, stl, rv, e_req;
            word_t rpc;
            e_req = m_started && (m_hold_q.size() == 0);
            check_outputs($sformatf("rand%0d", c), e_req, e_req ? m_pc : 32'h0,
                          m_v, m_instr, m_ipc, m_ipc4);
            rdy = ($urandom_range(0, 9) < 7);
            stl = ($urandom_range(0, 9) < 2);
            rv  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFF0 + word_t'($urandom_range(0, 15));
            else rpc = 32'h0000_3000 + word_t'($urandom_range(0, 4095));
            drive(rdy, stl, rv, rpc);
            model_step(rdy, stl, rv, rpc);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and issues fetch requests to instruction memory with a valid/ready handshake.
- Loads the IF/ID pipeline register. Its if_id_pc4 output feeds the next-PC calculator in ID, and it takes the computed branch/jump target back as a redirect.
- Branch delay slot semantics: the instruction in flight when a redirect arrives always completes and is delivered.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset (first fetch address).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  ID hazard stall; IF/ID must hold its contents
- redirect_valid  in  1  one-cycle pulse; a branch/jump in ID was taken
- redirect_pc  in  32  target from next-PC logic
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (byte address, bits[1:0]=00)
- imem_ready  in  1  response valid this cycle
- imem_rdata  in  32  instruction word, valid when imem_ready
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  fetched instruction
- if_id_pc  out  32  PC of if_id_instr
- if_id_pc4  out  32  if_id_pc + 4, modulo 2^32

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, redirect_pending=0.
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc4=0.
  - imem_req=0 while rst_n is low. imem_req rises on the first clock after deassertion.
- FSM states: FETCH, WAIT, HOLD.
- FETCH / WAIT:
  - imem_req=1, imem_addr=pc.
  - pc must stay stable while imem_req=1 and imem_ready=0.
  - WAIT is entered when a request is not answered in its first cycle. Latency is 1..N cycles, set by memory.
- Response cycle (imem_req && imem_ready):
  - stall=0: IF/ID <= {1, rdata, pc, pc+4}; pc <= next_pc; state=FETCH.
  - stall=1: rdata, pc and pc+4 are captured into a one-entry hold buffer; pc <= next_pc; state=HOLD. IF/ID is unchanged.
- No response and stall=0: if_id_valid <= 0 (bubble); instr/pc fields hold their values.
- stall=1 with no response: IF/ID holds all fields.
- HOLD:
  - imem_req=0.
  - When stall=0, IF/ID <= hold buffer with valid=1; state=FETCH.
- next_pc priority:
  - redirect_valid this cycle: {redirect_pc[31:2],2'b00}
  - else redirect_pending: pending target
  - else pc+4 (0xFFFFFFFC wraps to 0x00000000)
  - Using a redirect clears redirect_pending.
- Redirect with no response completing that cycle:
  - Latch redirect_pending=1 and the target.
  - The outstanding or next fetch of the current pc completes as the delay slot.
  - The redirect is applied to the pc after it.
- A second redirect while one is pending overwrites the target (later wins).
- Redirect during HOLD: pc has already advanced past the buffered delay slot, so pc <= target immediately. No pending is latched.
- Redirect bits[1:0] are ignored (forced to 00). No exception is raised in this block.
- Throughput: 1 instruction/cycle when imem_ready is tied high and stall=0.

Decomposition:
- Shared package (cpu_pkg):
  - RESET_PC default
  - MIPS NOP constant 32'h0000_0000
  - FSM state encoding typedef (FETCH/WAIT/HOLD)
- Optional sub-module if_id_reg: valid/instr/pc/pc4 register with load, bubble and hold controls.
- The PC and FSM stay in the top module.

Test Plan:
- Reset, imem_ready tied 1, stall=0 → imem_addr sequence 0x3000, 0x3004, 0x3008. if_id_pc follows one cycle later with valid=1; if_id_pc4=0x3004 when if_id_pc=0x3000.
- imem_ready low for 2 cycles on address 0x3004 → imem_addr holds 0x3004; if_id_valid=0 for 2 cycles; then the instruction at 0x3004 is delivered.
- redirect_valid pulse, redirect_pc=0x3100, while the fetch of 0x3008 gets its response → 0x3008 delivered as the delay slot; next imem_addr=0x3100.
- Redirect to 0x3200 while 0x300C is in WAIT → 0x300C completes; next imem_addr=0x3200; redirect_pending clears.
- stall=1 for 3 cycles during a response at 0x3010 → IF/ID holds; imem_req=0 in HOLD; after release 0x3010 is delivered, then fetch resumes at 0x3014 with no loss or duplication.
- Redirect target 0xFFFFFFFC, then run → addresses 0xFFFFFFFC, 0x00000000. Separately, assert rst_n low mid-WAIT → all outputs zero immediately; the first request after release is 0x3000.
